// File: rtl/code_tx_if.sv
// ---------------------------------------------------------------------------
// code_tx_if
// Bundles the request handshake, the station acknowledge and the serial
// line / status outputs of the code transmitter into one connection.
//
// Signals:
//   req_valid  controller asks for a code to be sent
//   code       4-bit user code, taken only when the request is accepted
//   req_ready  transmitter is idle and can take a request
//   ack        station acknowledge pulse
//   tx         serial line (idle high)
//   busy       transmitter is working on a request
//   done       one-cycle pulse, frame acknowledged
//   fail       one-cycle pulse, all attempts timed out
//   retry_cnt  retransmissions performed for the current request
//
// Modports:
//   master  controller / station side (drives req_valid, code, ack)
//   slave   transmitter side
// ---------------------------------------------------------------------------
interface code_tx_if;
   logic       req_valid;
   logic [3:0] code;
   logic       req_ready;
   logic       ack;
   logic       tx;
   logic       busy;
   logic       done;
   logic       fail;
   logic [1:0] retry_cnt;

   modport master (
      output req_valid, code, ack,
      input  req_ready, tx, busy, done, fail, retry_cnt
   );

   modport slave (
      input  req_valid, code, ack,
      output req_ready, tx, busy, done, fail, retry_cnt
   );
endinterface

// File: rtl/code_tx.sv
// ---------------------------------------------------------------------------
// code_tx
// Sending end of the scan link. Takes a 4-bit user code from the token
// controller, frames it (start bit, 4 data bits LSB first, optional parity,
// stop bit), waits for the station acknowledge and retransmits the same
// latched code on timeout until the retry allowance is used up. Reports the
// outcome with a one-cycle done or fail pulse.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    code_tx_if.slave (req_valid, code, req_ready, ack, tx, busy,
//          done, fail, retry_cnt)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   ACK_TIMEOUT   cycles to wait for ack after the stop bit (>= 1)
//   MAX_RETRY     retransmissions after the first attempt (0..3)
//
// Build option:
//   CODE_TX_PARITY_EN  when defined, an odd-parity bit of the latched code
//                      is sent between the data bits and the stop bit.
//                      The station receiver must be built the same way.
// ---------------------------------------------------------------------------
module code_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int ACK_TIMEOUT  = 16,
   parameter int MAX_RETRY    = 2
) (
   input  logic       clk,
   input  logic       reset,
   code_tx_if.slave   bus
);

   localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(ACK_TIMEOUT - 1);
   localparam logic [1:0]     RETRY_MAX = 2'(MAX_RETRY);

   // retry_cnt is only two bits wide, so more than three retries cannot be counted
   generate
      if (MAX_RETRY > 3 || MAX_RETRY < 0) begin : g_badRetry
         $error("code_tx: MAX_RETRY must be in 0..3");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef CODE_TX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_ACK,
      DONE,
      FAIL
   } state_t;

   state_t         r_state,  w_stateNext;
   logic [BCW-1:0] r_bitCnt, w_bitCntNext;
   logic [1:0]     r_bitIdx, w_bitIdxNext;
   logic [TCW-1:0] r_toCnt,  w_toCntNext;
   logic [3:0]     r_code,   w_codeNext;
   logic [1:0]     r_retry,  w_retryNext;
   logic           r_tx,     w_txNext;
   logic           w_bitLast;

   assign w_bitLast = (r_bitCnt == BIT_LAST);

   // State register plus all counters. tx is registered from the next-state
   // decode so the line changes on the same edge the state does, which puts
   // the first start-bit cycle right after the accept edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_bitCnt <= '0;
         r_bitIdx <= '0;
         r_toCnt  <= '0;
         r_code   <= '0;
         r_retry  <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_state  <= w_stateNext;
         r_bitCnt <= w_bitCntNext;
         r_bitIdx <= w_bitIdxNext;
         r_toCnt  <= w_toCntNext;
         r_code   <= w_codeNext;
         r_retry  <= w_retryNext;
         r_tx     <= w_txNext;
      end
   end

   // Next-state and counter decode. Every bit-timed state runs the bit
   // counter 0..CLKS_PER_BIT-1; WAIT_ACK runs the timeout counter instead.
   // An ack on the final timeout cycle is tested first so it wins over a
   // retry or a fail. Retransmission reuses r_code, never the live input.
   always_comb begin
      w_stateNext  = r_state;
      w_bitCntNext = r_bitCnt;
      w_bitIdxNext = r_bitIdx;
      w_toCntNext  = r_toCnt;
      w_codeNext   = r_code;
      w_retryNext  = r_retry;
      w_txNext     = 1'b1;

      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_stateNext  = START;
               w_codeNext   = bus.code;
               w_retryNext  = '0;
               w_bitCntNext = '0;
            end
         end
         START: begin
            if (w_bitLast) begin
               w_stateNext  = DATA;
               w_bitCntNext = '0;
               w_bitIdxNext = '0;
            end else begin
               w_bitCntNext = r_bitCnt + BCW'(1);
            end
         end
         DATA: begin
            if (w_bitLast) begin
               w_bitCntNext = '0;
               if (r_bitIdx == 2'd3) begin
`ifdef CODE_TX_PARITY_EN
                  w_stateNext = PARITY;
`else
                  w_stateNext = STOP;
`endif
               end else begin
                  w_bitIdxNext = r_bitIdx + 2'd1;
               end
            end else begin
               w_bitCntNext = r_bitCnt + BCW'(1);
            end
         end
`ifdef CODE_TX_PARITY_EN
         PARITY: begin
            if (w_bitLast) begin
               w_stateNext  = STOP;
               w_bitCntNext = '0;
            end else begin
               w_bitCntNext = r_bitCnt + BCW'(1);
            end
         end
`endif
         STOP: begin
            if (w_bitLast) begin
               w_stateNext  = WAIT_ACK;
               w_bitCntNext = '0;
               w_toCntNext  = '0;
            end else begin
               w_bitCntNext = r_bitCnt + BCW'(1);
            end
         end
         WAIT_ACK: begin
            if (bus.ack) begin
               w_stateNext = DONE;
            end else if (r_toCnt == TO_LAST) begin
               if (r_retry < RETRY_MAX) begin
                  w_retryNext  = r_retry + 2'd1;
                  w_stateNext  = START;
                  w_bitCntNext = '0;
               end else begin
                  w_stateNext = FAIL;
               end
            end else begin
               w_toCntNext = r_toCnt + TCW'(1);
            end
         end
         DONE:    w_stateNext = IDLE;
         FAIL:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase

      case (w_stateNext)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_codeNext[w_bitIdxNext];
`ifdef CODE_TX_PARITY_EN
         PARITY:  w_txNext = ~^w_codeNext;
`endif
         default: w_txNext = 1'b1;
      endcase
   end

   // Status outputs decode straight from the state register
   assign bus.req_ready = (r_state == IDLE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
   assign bus.fail      = (r_state == FAIL);
   assign bus.retry_cnt = r_retry;
   assign bus.tx        = r_tx;

endmodule

// File: tb/tb_code_tx.sv
// ---------------------------------------------------------------------------
// tb_code_tx
// Self-checking bench for code_tx. A table of request records drives the
// main cases; expected line bits are pushed to a queue when a frame is due
// and popped cycle by cycle, expected outcomes are pushed at accept and
// popped at the done/fail cycle. Reset behaviour is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_code_tx;

   localparam int C  = 4;
   localparam int T  = 16;
   localparam int MR = 2;
`ifdef CODE_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F = (6 + P) * C;

   typedef struct {
      logic [3:0] code;
      logic [3:0] codeAfter;
      int         ackAttempt;
      int         ackCycle;
      bit         ackInData;
      bit         expDone;
      bit         expFail;
      logic [1:0] expRetry;
   } vec_t;

   typedef struct {
      bit         done;
      bit         fail;
      logic [1:0] retry;
   } result_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic    txQ[$];
   result_t resQ[$];
   vec_t    vecs[7];

   code_tx_if bus();

   code_tx #(
      .CLKS_PER_BIT(C),
      .ACK_TIMEOUT (T),
      .MAX_RETRY   (MR)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the DUT wedges somewhere unexpected
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one frame on the line, one entry per clock cycle
   task automatic pushFrame(input logic [3:0] c);
      for (int k = 0; k < C; k++) txQ.push_back(1'b0);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < C; k++) txQ.push_back(c[i]);
`ifdef CODE_TX_PARITY_EN
      for (int k = 0; k < C; k++) txQ.push_back(~^c);
`endif
      for (int k = 0; k < C; k++) txQ.push_back(1'b1);
   endtask

   // One full request: accept, frames, optional ack, outcome pulse, idle
   task automatic applyStimulus(input vec_t v);
      int      waitCnt;
      int      cyc;
      int      expLat;
      bit      acked;
      logic    expTx;
      result_t r;
      waitCnt = 0;
      while (bus.req_ready !== 1'b1 && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.code      = v.code;
      pushFrame(v.code);
      resQ.push_back('{v.expDone, v.expFail, v.expRetry});
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.code      = v.codeAfter;
      cyc   = 1;
      acked = 1'b0;
      for (int a = 0; a <= MR && !acked; a++) begin
         for (int k = 0; k < F; k++) begin
            if (txQ.size() == 0) begin
               checkOutput("tx_queue_empty", 32'd0, 32'd1);
               expTx = 1'b1;
            end else begin
               expTx = txQ.pop_front();
            end
            checkOutput("tx_frame", {31'd0, bus.tx}, {31'd0, expTx});
            checkOutput("busy_frame", {31'd0, bus.busy}, 32'd1);
            checkOutput("pulse_frame", {30'd0, bus.done, bus.fail}, 32'd0);
            bus.ack = (v.ackInData && a == 0 && k == C + 1);
            @(negedge clk);
            cyc++;
         end
         bus.ack = 1'b0;
         for (int w = 1; w <= T && !acked; w++) begin
            checkOutput("tx_wait", {31'd0, bus.tx}, 32'd1);
            checkOutput("busy_wait", {31'd0, bus.busy}, 32'd1);
            checkOutput("retry_wait", {30'd0, bus.retry_cnt}, a);
            checkOutput("pulse_wait", {30'd0, bus.done, bus.fail}, 32'd0);
            if (a == v.ackAttempt && w == v.ackCycle) begin
               bus.ack = 1'b1;
               acked   = 1'b1;
            end
            @(negedge clk);
            cyc++;
            bus.ack = 1'b0;
         end
         if (!acked && a < MR) pushFrame(v.code);
      end
      r = resQ.pop_front();
      checkOutput("done_pulse", {31'd0, bus.done}, {31'd0, r.done});
      checkOutput("fail_pulse", {31'd0, bus.fail}, {31'd0, r.fail});
      checkOutput("busy_pulse", {31'd0, bus.busy}, 32'd1);
      checkOutput("ready_pulse", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("retry_final", {30'd0, bus.retry_cnt}, {30'd0, r.retry});
      if (r.done) begin
         expLat = v.ackAttempt * (F + T) + F + v.ackCycle + 1;
         checkOutput("done_latency", cyc, expLat);
      end
      @(negedge clk);
      checkOutput("busy_after", {31'd0, bus.busy}, 32'd0);
      checkOutput("ready_after", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("pulse_after", {30'd0, bus.done, bus.fail}, 32'd0);
      checkOutput("retry_hold", {30'd0, bus.retry_cnt}, {30'd0, r.retry});
   endtask

   // Main sequence: reset checks, table of requests, mid-frame reset
   initial begin
      checks   = 0;
      failures = 0;
      //           code     after    att  cyc  inData done fail retry
      vecs[0] = '{4'b1011, 4'b1011,  0,   3,  1'b0, 1'b1, 1'b0, 2'd0};
      vecs[1] = '{4'h5,    4'h5,    -1,   0,  1'b0, 1'b0, 1'b1, 2'd2};
      vecs[2] = '{4'h3,    4'hA,     1,   1,  1'b0, 1'b1, 1'b0, 2'd1};
      vecs[3] = '{4'hF,    4'hF,     0,  16,  1'b1, 1'b1, 1'b0, 2'd0};
      vecs[4] = '{4'b0110, 4'b0110,  0,   1,  1'b0, 1'b1, 1'b0, 2'd0};
      vecs[5] = '{4'b0111, 4'b0111,  0,   2,  1'b0, 1'b1, 1'b0, 2'd0};
      vecs[6] = '{4'h0,    4'h9,     2,  16,  1'b0, 1'b1, 1'b0, 2'd2};

      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.code      = 4'h0;
      bus.ack       = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_tx", {31'd0, bus.tx}, 32'd1);
      checkOutput("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_pulses", {30'd0, bus.done, bus.fail}, 32'd0);
      checkOutput("rst_retry", {30'd0, bus.retry_cnt}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      // Reset in the middle of the data bits must abort silently
      bus.req_valid = 1'b1;
      bus.code      = 4'h9;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_tx", {31'd0, bus.tx}, 32'd1);
      checkOutput("async_ready", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("async_busy", {31'd0, bus.busy}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("rst_no_pulse", {30'd0, bus.done, bus.fail}, 32'd0);
         checkOutput("rst_hold_tx", {31'd0, bus.tx}, 32'd1);
      end
      reset = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_retry", {30'd0, bus.retry_cnt}, 32'd0);
      applyStimulus('{4'h9, 4'h9, 0, 1, 1'b0, 1'b1, 1'b0, 2'd0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/code_tx.md
Name: code_tx

Overview:
- Card/token-side transmitter that delivers a 4-bit user code to the station scanner over a single serial line.
- Frames the code, waits for the station's acknowledge, and retransmits on timeout up to a retry limit.
- Reports success or failure to the local controller.
- Sits between the token controller and the station scanner input. It is the sending end of the scan link.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range >= 1
ACK_TIMEOUT, 16, cycles to wait for ack after stop bit; legal range >= 1
MAX_RETRY, 2, retransmissions allowed after the first attempt; 0 means single attempt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  controller requests transmission of code
code  input  4  user code, sampled only on accept
req_ready  output  1  high when block can accept a request (IDLE only)
ack  input  1  station acknowledge pulse, synchronous to clk
tx  output  1  serial line, idle high, registered
busy  output  1  high from accept until done/fail pulse cycle inclusive
done  output  1  one-cycle pulse: frame acknowledged
fail  output  1  one-cycle pulse: retries exhausted
retry_cnt  output  2  retransmissions performed for current request

Behaviour:
- Reset (reset low, asynchronous) values:
  - FSM to IDLE; tx=1, req_ready=1, busy=0, done=0, fail=0, retry_cnt=0.
  - Bit/timeout counters cleared; latched code cleared.
- Reset mid-frame aborts immediately. tx returns high and no done/fail pulse is issued.
- States: IDLE, START, DATA, PARITY (feature-gated), STOP, WAIT_ACK, DONE, FAIL.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 on a clk edge: latch code, clear retry_cnt, go to START.
  - req_valid outside IDLE is ignored. The requester holds it until accepted.
- START: tx=0 for CLKS_PER_BIT cycles. The first low cycle is the cycle after accept.
- DATA:
  - 4 bits, LSB first, each held CLKS_PER_BIT cycles.
  - A bit index 0..3 advances when the bit counter reaches CLKS_PER_BIT-1.
- PARITY: see Optional Feature.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to WAIT_ACK.
- WAIT_ACK:
  - tx=1; timeout counter counts 0..ACK_TIMEOUT-1.
  - ack=1 in any WAIT_ACK cycle -> DONE.
  - Counter reaches ACK_TIMEOUT-1 without ack:
    - If retry_cnt < MAX_RETRY: retry_cnt increments and the FSM goes to START, resending the latched code (not the current code input).
    - Otherwise go to FAIL.
  - If ack arrives on the final timeout cycle, ack wins -> DONE.
- DONE / FAIL:
  - Single-cycle states: done=1 or fail=1 respectively, busy=1, then IDLE.
  - req_ready returns high the cycle after the pulse.
  - retry_cnt holds its value until the next accept.
- ack outside WAIT_ACK is ignored and is not remembered.
- Frame length F = (6+P)*CLKS_PER_BIT cycles, where P=1 with parity, 0 without.
- Accept-to-done latency with an ack on the first WAIT_ACK cycle = F+2 cycles.
- retry_cnt saturates by construction. MAX_RETRY must be <= 3; larger values are a configuration error, asserted at elaboration.

Optional Feature:
- Macro CODE_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = odd parity of the latched code (~^code) for CLKS_PER_BIT cycles; P=1.
- Undefined: DATA goes directly to STOP; P=0. No parity logic is synthesised.
- The station receiver build must use the same setting.

Test Plan:
1. Defaults, no parity, code=4'b1011, ack pulsed at the 3rd WAIT_ACK cycle:
   - Line sequence 0,1,1,0,1,1, each held 4 cycles.
   - done pulses once, retry_cnt=0, busy drops the cycle after done.
2. CODE_TX_PARITY_EN defined, code=4'b0110:
   - Parity bit=1 held 4 cycles between the data bits and the stop bit.
   - Frame is 28 cycles.
   - code=4'b0111 -> parity bit=0.
3. ack never asserted, MAX_RETRY=2, code=4'h5:
   - Three identical frames, each followed by 16 WAIT_ACK cycles.
   - retry_cnt reads 1, then 2; fail pulses once; done never asserts.
4. code input changed to 4'hA after accept of 4'h3, no ack on the first attempt:
   - The retransmitted frame still carries 4'h3.
5. ack on exactly the 16th WAIT_ACK cycle -> done, no retry. ack during the DATA bits is ignored and the frame completes normally.
6. reset driven low mid-DATA:
   - tx=1 and req_ready=1 asynchronously; no done/fail pulse.
   - A new request after release transmits a clean frame.
